deck_receiver: RTL and testbench

//   Receiving end of the shuffler's card-load interface. Samples the load_flag/card stream,

---
 rtl/blackjack_pkg.sv | 25 ++
 rtl/deck_ram.sv | 37 +++
 rtl/deck_receiver.sv | 167 ++++++++++++++++
 tb/tb_deck_receiver.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared deck parameters, FSM state encoding and the load-phase helper for deck_receiver.
package blackjack_pkg;

  localparam int DECK_SIZE     = 52;
  localparam int CARD_W        = 6;
  localparam int LOAD_INTERVAL = 2;

  localparam int PHASE_W = (LOAD_INTERVAL > 1) ? $clog2(LOAD_INTERVAL) : 1;
  localparam int PTR_W   = $clog2(DECK_SIZE + 1);
  localparam int ADDR_W  = $clog2(DECK_SIZE);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_EMPTY = 2'd3;

  function automatic logic [PHASE_W-1:0] phase_next(input logic [PHASE_W-1:0] p);
    if (p == PHASE_W'(LOAD_INTERVAL - 1)) begin
      return {PHASE_W{1'b0}};
    end else begin
      return p + PHASE_W'(1);
    end
  endfunction

endpackage

// File: rtl/deck_ram.sv
// Deck storage: one synchronous write port and one registered read port that holds between reads.
module deck_ram #(
  parameter int DEPTH = 52,
  parameter int WIDTH = 6,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Array contents are not reset; they are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= {WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/deck_receiver.sv
// Captures the shuffled deck from the shuffler and deals it one card per request.
// Optional duplicate/range checker enabled by the DECK_DUP_CHECK_EN macro.
module deck_receiver
  import blackjack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_flag,
  input  logic [CARD_W-1:0] card_in,
  input  logic              deal_req,
  output logic              deal_valid,
  output logic [CARD_W-1:0] deal_card,
  output logic [CARD_W-1:0] cards_left,
  output logic              deck_ready,
  output logic              deck_empty,
  output logic              reshuffle_req,
  output logic              load_error
);

  logic [1:0]         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CARD_W-1:0]  cards_left_q, cards_left_d;
  logic               deal_valid_q, deal_valid_d;
  logic               capture_s;
  logic               deal_s;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    cards_left_d = cards_left_q;
    deal_valid_d = 1'b0;
    capture_s    = 1'b0;
    deal_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_flag) begin
          state_d = ST_LOAD;
          phase_d = {PHASE_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // An aborted load discards everything captured so far.
        if (!load_flag) begin
          state_d      = ST_IDLE;
          phase_d      = {PHASE_W{1'b0}};
          wptr_d       = {PTR_W{1'b0}};
          cards_left_d = {CARD_W{1'b0}};
        end else begin
          phase_d = phase_next(phase_q);
          if (phase_q == {PHASE_W{1'b0}}) begin
            capture_s    = 1'b1;
            wptr_d       = wptr_q + PTR_W'(1);
            cards_left_d = CARD_W'(wptr_q + PTR_W'(1));
            if (wptr_q == PTR_W'(DECK_SIZE - 1)) begin
              state_d = ST_READY;
              rptr_d  = {PTR_W{1'b0}};
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            capture_s = 1'b0;
          end
        end
      end
      ST_READY: begin
        if (deal_req) begin
          deal_s       = 1'b1;
          deal_valid_d = 1'b1;
          rptr_d       = rptr_q + PTR_W'(1);
          cards_left_d = cards_left_q - CARD_W'(1);
          if (cards_left_q == CARD_W'(1)) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_READY;
          end
        end else begin
          deal_s = 1'b0;
        end
      end
      ST_EMPTY: begin
        state_d = ST_EMPTY;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= {PHASE_W{1'b0}};
      wptr_q       <= {PTR_W{1'b0}};
      rptr_q       <= {PTR_W{1'b0}};
      cards_left_q <= {CARD_W{1'b0}};
      deal_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cards_left_q <= cards_left_d;
      deal_valid_q <= deal_valid_d;
    end
  end

  deck_ram #(
    .DEPTH (DECK_SIZE),
    .WIDTH (CARD_W),
    .AW    (ADDR_W)
  ) u_deck_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (capture_s),
    .wr_addr (wptr_q[ADDR_W-1:0]),
    .wr_data (card_in),
    .rd_en   (deal_s),
    .rd_addr (rptr_q[ADDR_W-1:0]),
    .rd_data (deal_card)
  );

`ifdef DECK_DUP_CHECK_EN
  logic [DECK_SIZE-1:0] seen_q, seen_d;
  logic                 load_error_q, load_error_d;
  logic                 dup_s;
  logic                 range_err_s;

  // Out-of-range codes match no seen bit, so they only raise the range error.
  always_comb begin
    seen_d      = seen_q;
    dup_s       = 1'b0;
    range_err_s = (card_in >= CARD_W'(DECK_SIZE));
    for (int i = 0; i < DECK_SIZE; i++) begin
      seen_d[i] = seen_q[i] | (capture_s & (card_in == CARD_W'(i)));
      dup_s     = dup_s | (seen_q[i] & (card_in == CARD_W'(i)));
    end
    load_error_d = load_error_q | (capture_s & (dup_s | range_err_s));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q       <= {DECK_SIZE{1'b0}};
      load_error_q <= 1'b0;
    end else begin
      seen_q       <= seen_d;
      load_error_q <= load_error_d;
    end
  end

  assign load_error = load_error_q;
`else
  assign load_error = 1'b0;
`endif

  assign deal_valid    = deal_valid_q;
  assign cards_left    = cards_left_q;
  assign deck_ready    = (state_q == ST_READY);
  assign deck_empty    = (state_q == ST_EMPTY);
  assign reshuffle_req = (state_q == ST_EMPTY);

endmodule

// File: tb/tb_deck_receiver.sv
// Directed self-checking bench for deck_receiver: load, deal, empty, reset, duplicate and abort cases.
module tb_deck_receiver;

  logic       clk;
  logic       rst_n;
  logic       load_flag;
  logic [5:0] card_in;
  logic       deal_req;
  logic       deal_valid;
  logic [5:0] deal_card;
  logic [5:0] cards_left;
  logic       deck_ready;
  logic       deck_empty;
  logic       reshuffle_req;
  logic       load_error;

  int checks = 0;
  int fails  = 0;
  logic [5:0] codes [52];

  deck_receiver dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_flag     (load_flag),
    .card_in       (card_in),
    .deal_req      (deal_req),
    .deal_valid    (deal_valid),
    .deal_card     (deal_card),
    .cards_left    (cards_left),
    .deck_ready    (deck_ready),
    .deck_empty    (deck_empty),
    .reshuffle_req (reshuffle_req),
    .load_error    (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n     = 1'b0;
    load_flag = 1'b0;
    deal_req  = 1'b0;
    card_in   = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [5:0] first);
    load_flag = 1'b1;
    card_in   = first;
    @(posedge clk);
    #1;
  endtask

  task automatic capture_one(input logic [5:0] code, input bit more);
    card_in = code;
    @(posedge clk);
    #1;
    if (more) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({deal_valid, deal_card, cards_left, deck_ready, deck_empty, reshuffle_req, load_error} !== 17'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {deal_valid, deal_card, cards_left, deck_ready, deck_empty, reshuffle_req, load_error});
    end
  endtask

  task automatic test_full_load();
    for (int i = 0; i < 52; i++) codes[i] = 6'(51 - i);
    start_load(codes[0]);
    for (int i = 0; i < 52; i++) begin
      if (i == 51) begin
        checks++;
        if (deck_ready !== 1'b0 || cards_left !== 6'd51) begin
          fails++;
          $display("FAIL pre_last_capture: ready=%0d left=%0d expected ready=0 left=51", deck_ready, cards_left);
        end
      end
      capture_one(codes[i], i < 51);
    end
    checks++;
    if (deck_ready !== 1'b1 || cards_left !== 6'd52 || deal_valid !== 1'b0) begin
      fails++;
      $display("FAIL load_done: ready=%0d left=%0d valid=%0d expected 1 52 0", deck_ready, cards_left, deal_valid);
    end
  endtask

  task automatic test_back_to_back();
    deal_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) deal_req = 1'b0;
      checks++;
      if (deal_valid !== 1'b1 || deal_card !== 6'(51 - k) || cards_left !== 6'(51 - k)) begin
        fails++;
        $display("FAIL b2b_deal%0d: valid=%0d card=%0d left=%0d expected 1 %0d %0d",
                 k, deal_valid, deal_card, cards_left, 51 - k, 51 - k);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (deal_valid !== 1'b0 || deal_card !== 6'd49 || cards_left !== 6'd49) begin
      fails++;
      $display("FAIL b2b_hold: valid=%0d card=%0d left=%0d expected 0 49 49", deal_valid, deal_card, cards_left);
    end
  endtask

  task automatic test_deal_all();
    for (int k = 3; k < 52; k++) begin
      deal_req = 1'b1;
      @(posedge clk);
      #1;
      deal_req = 1'b0;
      checks++;
      if (deal_valid !== 1'b1 || deal_card !== 6'(51 - k) || cards_left !== 6'(51 - k)) begin
        fails++;
        $display("FAIL deal%0d: valid=%0d card=%0d left=%0d expected 1 %0d %0d",
                 k, deal_valid, deal_card, cards_left, 51 - k, 51 - k);
      end
      if (k == 51) begin
        checks++;
        if (deck_empty !== 1'b1 || reshuffle_req !== 1'b1 || deck_ready !== 1'b0) begin
          fails++;
          $display("FAIL empty_entry: empty=%0d reshuffle=%0d ready=%0d expected 1 1 0",
                   deck_empty, reshuffle_req, deck_ready);
        end
      end
      @(posedge clk);
      #1;
    end
    deal_req  = 1'b1;
    load_flag = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (deal_valid !== 1'b0 || deck_empty !== 1'b1 || reshuffle_req !== 1'b1 || cards_left !== 6'd0) begin
        fails++;
        $display("FAIL empty_hold%0d: valid=%0d empty=%0d reshuffle=%0d left=%0d expected 0 1 1 0",
                 k, deal_valid, deck_empty, reshuffle_req, cards_left);
      end
    end
    deal_req = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    int bad;
    do_reset();
    for (int i = 0; i < 52; i++) codes[i] = 6'((i * 5 + 3) % 52);
    start_load(codes[0]);
    for (int i = 0; i < 20; i++) capture_one(codes[i], 1'b1);
    checks++;
    if (cards_left !== 6'd20) begin
      fails++;
      $display("FAIL mid_load_count: got %0d expected 20", cards_left);
    end
    rst_n     = 1'b0;
    load_flag = 1'b0;
    #1;
    checks++;
    if ({deal_valid, deal_card, cards_left, deck_ready, deck_empty, reshuffle_req, load_error} !== 17'd0) begin
      fails++;
      $display("FAIL async_reset: got %b expected all zero",
               {deal_valid, deal_card, cards_left, deck_ready, deck_empty, reshuffle_req, load_error});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_load(codes[0]);
    for (int i = 0; i < 52; i++) capture_one(codes[i], i < 51);
    checks++;
    if (deck_ready !== 1'b1 || cards_left !== 6'd52) begin
      fails++;
      $display("FAIL reload_done: ready=%0d left=%0d expected 1 52", deck_ready, cards_left);
    end
    bad = 0;
    deal_req = 1'b1;
    for (int k = 0; k < 52; k++) begin
      @(posedge clk);
      #1;
      if (k == 51) deal_req = 1'b0;
      if (deal_valid !== 1'b1 || deal_card !== codes[k]) bad++;
    end
    checks++;
    if (bad != 0 || deck_empty !== 1'b1) begin
      fails++;
      $display("FAIL reload_deal_order: bad=%0d empty=%0d expected 0 1", bad, deck_empty);
    end
  endtask

  task automatic test_dup_check();
    logic exp_err;
    do_reset();
    for (int i = 0; i < 52; i++) codes[i] = 6'(51 - i);
    codes[0] = 6'd7;
    start_load(codes[0]);
    for (int i = 0; i < 52; i++) begin
      capture_one(codes[i], i < 51);
`ifdef DECK_DUP_CHECK_EN
      exp_err = (i >= 44);
`else
      exp_err = 1'b0;
`endif
      if (i == 0 || i == 43 || i == 44 || i == 51) begin
        checks++;
        if (load_error !== exp_err) begin
          fails++;
          $display("FAIL dup_err_cap%0d: got %0d expected %0d", i, load_error, exp_err);
        end
      end
    end
    deal_req = 1'b1;
    @(posedge clk);
    #1;
    deal_req = 1'b0;
    checks++;
    if (deal_valid !== 1'b1 || deal_card !== 6'd7 || load_error !== exp_err) begin
      fails++;
      $display("FAIL dup_after_load: valid=%0d card=%0d err=%0d expected 1 7 %0d",
               deal_valid, deal_card, load_error, exp_err);
    end
  endtask

  task automatic test_load_drop();
    do_reset();
    start_load(6'd20);
    for (int i = 0; i < 10; i++) capture_one(6'(20 + i), 1'b1);
    checks++;
    if (cards_left !== 6'd10 || deck_ready !== 1'b0) begin
      fails++;
      $display("FAIL drop_pre: left=%0d ready=%0d expected 10 0", cards_left, deck_ready);
    end
    load_flag = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (cards_left !== 6'd0 || deck_ready !== 1'b0 || deck_empty !== 1'b0) begin
      fails++;
      $display("FAIL drop_idle: left=%0d ready=%0d empty=%0d expected 0 0 0", cards_left, deck_ready, deck_empty);
    end
    deal_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (deal_valid !== 1'b0 || cards_left !== 6'd0) begin
        fails++;
        $display("FAIL drop_no_deal%0d: valid=%0d left=%0d expected 0 0", k, deal_valid, cards_left);
      end
    end
    deal_req = 1'b0;
    start_load(6'd30);
    capture_one(6'd30, 1'b1);
    checks++;
    if (cards_left !== 6'd1) begin
      fails++;
      $display("FAIL drop_restart: left=%0d expected 1", cards_left);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    load_flag = 1'b0;
    deal_req  = 1'b0;
    card_in   = 6'd0;
    test_reset();
    test_full_load();
    test_back_to_back();
    test_deal_all();
    test_reset_mid_load();
    test_dup_check();
    test_load_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
